// File: rtl/operand_loader_pkg.sv
// Shared defaults, types and helpers for the double-buffered operand loader.
package operand_loader_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int N_ELEMS_DEF = 18;

  typedef logic bank_sel_t;

  // Fill counter width; a single-element set would still need one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/operand_bank.sv
// One operand bank: N_ELEMS x DATA_W registers, indexed write, flat read bus.
module operand_bank
  import operand_loader_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int N_ELEMS = N_ELEMS_DEF,
  parameter int CNT_W   = cnt_w(N_ELEMS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      we_i,
  input  logic [CNT_W-1:0]          widx_i,
  input  logic [DATA_W-1:0]         wdata_i,
  output logic [N_ELEMS*DATA_W-1:0] rdata_o
);

  for (genvar k = 0; k < N_ELEMS; k++) begin : g_elem
    logic [DATA_W-1:0] elem_q;

    // NOTE: this storage is reset on purpose so out_data reads zero after
    // reset; plain data arrays normally skip the reset to save routing.
    always_ff @(posedge clk) begin
      if (!reset) begin
        elem_q <= '0;
      end else if (we_i && (widx_i == CNT_W'(k))) begin
        elem_q <= wdata_i;
      end
    end

    assign rdata_o[k*DATA_W +: DATA_W] = elem_q;
  end

endmodule

// File: rtl/operand_loader.sv
// Double-buffered operand loader: byte-serial fill into one bank while the
// multiplier core consumes the other as a flat parallel bus.
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int N_ELEMS = N_ELEMS_DEF,
  parameter int CNT_W   = cnt_w(N_ELEMS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [DATA_W-1:0]         data_in,
  input  logic                      data_valid,
  output logic                      data_ready,
  output logic                      out_valid,
  output logic [N_ELEMS*DATA_W-1:0] out_data,
  input  logic                      out_ack,
  output logic [CNT_W-1:0]          fill_count
);

  bank_sel_t         wr_sel_q, wr_sel_d;
  bank_sel_t         rd_sel_q, rd_sel_d;
  logic [1:0]        full_q, full_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              accept;
  logic              ack;
  logic              last_elem;
  logic [1:0]        bank_we;
  logic [N_ELEMS*DATA_W-1:0] bank_rdata [2];

  // Ready depends only on state, so there is no path from data_valid.
  assign data_ready = !full_q[wr_sel_q];
  assign accept     = data_valid && data_ready;
  assign ack        = out_ack && out_valid;
  assign last_elem  = (count_q == CNT_W'(N_ELEMS - 1));

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign bank_we[b] = accept && !flush && (wr_sel_q == bank_sel_t'(b));

    operand_bank #(
      .DATA_W  (DATA_W),
      .N_ELEMS (N_ELEMS),
      .CNT_W   (CNT_W)
    ) u_bank (
      .clk     (clk),
      .reset   (reset),
      .we_i    (bank_we[b]),
      .widx_i  (count_q),
      .wdata_i (data_in),
      .rdata_o (bank_rdata[b])
    );
  end

  // NOTE: every _d gets its hold value first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    count_d  = count_q;
    full_d   = full_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    if (flush) begin
      count_d  = '0;
      full_d   = '0;
      wr_sel_d = 1'b0;
      rd_sel_d = 1'b0;
    end else begin
      if (accept) begin
        if (last_elem) begin
          full_d[wr_sel_q] = 1'b1;
          wr_sel_d         = ~wr_sel_q;
          count_d          = '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      // The write bank is never full, so this never touches the bank set above.
      if (ack) begin
        full_d[rd_sel_q] = 1'b0;
        rd_sel_d         = ~rd_sel_q;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q  <= '0;
      full_q   <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      full_q   <= full_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
    end
  end

  assign out_valid  = full_q[rd_sel_q];
  assign out_data   = rd_sel_q ? bank_rdata[1] : bank_rdata[0];
  assign fill_count = count_q;

endmodule

// File: tb/tb_operand_loader.sv
// Self-checking bench for operand_loader: vector table plus a set scoreboard.
module tb_operand_loader;

  localparam int DW = 8;
  localparam int N  = 18;
  localparam int CW = $clog2(N);
  localparam int W  = N * DW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          data_valid = 1'b0;
  logic          data_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ack = 1'b0;
  logic [CW-1:0] fill_count;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] sb_q[$];
  logic [W-1:0] exp_set = '0;
  int           exp_idx = 0;
  int           sets_acked = 0;

  typedef struct {
    logic          dv;
    logic [DW-1:0] d;
    logic          ack;
    logic          fl;
    logic          exp_ready;
    logic          exp_valid;
    int            exp_fill;
  } vec_t;

  vec_t vecs[8];

  operand_loader #(
    .DATA_W  (DW),
    .N_ELEMS (N)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ack    (out_ack),
    .fill_count (fill_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    sb_q.delete();
    exp_idx = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    data_valid = 1'b0;
    out_ack = 1'b0;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    clear_model();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_fill_count", fill_count, '0);
    check("rst_data_ready", data_ready, 1'b1);
  endtask

  // One clock of stimulus; outputs are checked #1 after the edge.
  task automatic step(input logic dv, input logic [DW-1:0] d, input logic ack, input logic fl);
    logic acc, ak;
    acc = dv && data_ready && !fl;
    ak  = ack && out_valid && !fl;
    if (ak) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ack_set: out_valid high with no completed set expected");
      end else begin
        check("ack_out_data", out_data, sb_q[0]);
        void'(sb_q.pop_front());
        sets_acked++;
      end
    end
    data_valid = dv;
    data_in    = d;
    out_ack    = ack;
    flush      = fl;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    out_ack    = 1'b0;
    flush      = 1'b0;
    if (fl) begin
      clear_model();
    end else if (acc) begin
      exp_set[exp_idx*DW +: DW] = d;
      if (exp_idx == N - 1) begin
        sb_q.push_back(exp_set);
        exp_idx = 0;
      end else begin
        exp_idx++;
      end
    end
    check("fill_count", fill_count, exp_idx);
    check("out_valid", out_valid, sb_q.size() != 0);
    check("data_ready", data_ready, sb_q.size() < 2);
    if (sb_q.size() != 0) check("out_data", out_data, sb_q[0]);
  endtask

  initial begin
    int stalls;

    // Partial fills, ignored acks and flush priority over accept.
    vecs[0] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    vecs[1] = '{1'b0, 8'h99, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    vecs[2] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 2};
    vecs[3] = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b0, 3};
    vecs[4] = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 1'b0, 0};
    vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 0};
    vecs[6] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    vecs[7] = '{1'b1, 8'h66, 1'b1, 1'b1, 1'b1, 1'b0, 0};

    // Single set, no ack.
    do_reset();
    for (int i = 0; i < N; i++) step(1'b1, DW'(i + 1), 1'b0, 1'b0);
    check("t1_valid", out_valid, 1'b1);
    check("t1_elem0", out_data[7:0], 8'h01);
    check("t1_elem17", out_data[143:136], 8'h12);
    check("t1_ready", data_ready, 1'b1);
    check("t1_fill", fill_count, '0);

    // Both banks full, back-pressure, then ack.
    do_reset();
    for (int i = 0; i < 2 * N; i++) step(1'b1, DW'(8'h40 + i), 1'b0, 1'b0);
    check("t2_ready_low", data_ready, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    check("t2_held_fill", fill_count, '0);
    step(1'b1, 8'hEF, 1'b1, 1'b0);
    check("t2_valid_after_ack", out_valid, 1'b1);
    check("t2_bank1_elem0", out_data[7:0], 8'h52);
    check("t2_ready_after_ack", data_ready, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Continuous stream, ack on first valid cycle.
    do_reset();
    stalls = 0;
    sets_acked = 0;
    for (int i = 0; i < 256; i++) begin
      if (!data_ready) stalls++;
      step(1'b1, DW'(i), out_valid, 1'b0);
    end
    check("t3_no_stall", stalls, 0);
    check("t3_sets_acked", sets_acked, 14);

    // Set completion on bank 1 in the same cycle bank 0 is acked.
    do_reset();
    for (int i = 0; i < N; i++) step(1'b1, DW'(i + 1), 1'b0, 1'b0);
    for (int i = 0; i < N - 1; i++) step(1'b1, DW'(8'h80 + i), 1'b0, 1'b0);
    step(1'b1, DW'(8'h80 + N - 1), 1'b1, 1'b0);
    check("t4_valid", out_valid, 1'b1);
    check("t4_bank1_elem0", out_data[7:0], 8'h80);
    check("t4_ready", data_ready, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("t4_drained", out_valid, 1'b0);

    // Vector table, then flush mid-load and reload.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].dv, vecs[i].d, vecs[i].ack, vecs[i].fl);
      check($sformatf("vec%0d_ready", i), data_ready, vecs[i].exp_ready);
      check($sformatf("vec%0d_valid", i), out_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d_fill", i), fill_count, vecs[i].exp_fill);
    end
    for (int i = 0; i < 7; i++) step(1'b1, DW'(8'h10 + i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("t5_fill_after_flush", fill_count, '0);
    for (int i = 0; i < N; i++) step(1'b1, DW'(8'hA0 + i), 1'b0, 1'b0);
    check("t5_elem0", out_data[7:0], 8'hA0);
    check("t5_elem17", out_data[143:136], 8'hB1);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Reset mid-load with data_valid high.
    do_reset();
    for (int i = 0; i < N + 5; i++) step(1'b1, DW'(8'h30 + i), 1'b0, 1'b0);
    reset = 1'b0;
    data_valid = 1'b1;
    data_in = 8'hFF;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    reset = 1'b1;
    clear_model();
    check("t6_out_valid", out_valid, 1'b0);
    check("t6_out_data", out_data, '0);
    check("t6_fill_count", fill_count, '0);
    check("t6_data_ready", data_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_loader.md
# operand_loader

Parametrised, double-buffered operand loader for the array multiplier datapath. It accepts a byte-serial stream of operand elements and assembles each group of `N_ELEMS` elements into one of two storage banks. It presents each completed bank to the multiplier core as a flat parallel bus. While the core consumes one bank, the next operand set loads into the other, so back-to-back multiplies run without stalling the input stream.

## Interface
Parameters:
- `DATA_W`, 8, width of one operand element
- `N_ELEMS`, 18, elements per operand set (default: two 3x3 matrices); must be ≥ 2
- `CNT_W`, `$clog2(N_ELEMS)`, width of the fill counter (derived; do not override)

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-low reset
- `flush`  in  1  synchronous abort: discards partial and completed sets
- `data_in`  in  DATA_W  element to store
- `data_valid`  in  1  `data_in` is valid this cycle
- `data_ready`  out  1  loader can accept an element this cycle
- `out_valid`  out  1  a complete operand set is presented on `out_data`
- `out_data`  out  N_ELEMS*DATA_W  element k at `[k*DATA_W +: DATA_W]`
- `out_ack`  in  1  consumer releases the presented set
- `fill_count`  out  CNT_W  elements already written into the current write bank

## Operation
State:
- Two banks.
- `full[1:0]` flags.
- `wr_sel` and `rd_sel` pointers.
- `count` (this is `fill_count`).

Input side:
- Element accept: `data_valid && data_ready`.
- `data_ready` is combinational and equals `!full[wr_sel]`.
- On accept, `data_in` is written to `bank[wr_sel][count]`.
  - If `count != N_ELEMS-1`: increment `count`.
  - Otherwise: set `full[wr_sel]`, toggle `wr_sel`, and clear `count` to 0.

Output side:
- `out_valid = full[rd_sel]` and `out_data = bank[rd_sel]`. Both come straight from registers.
- Ack: `out_ack && out_valid` clears `full[rd_sel]` and toggles `rd_sel`.
- `out_ack` while `!out_valid` is ignored.

Simultaneous events:
- If a set completes and an ack occurs in the same cycle on different banks, both take effect.
- A same-bank collision is impossible: the write bank is never full.

Data handling:
- Element order is arrival order. Index 0 is the first element accepted after reset, flush, or a bank switch.
- No arithmetic is performed on the data. The counter wraps only through the explicit clear at `N_ELEMS-1`.

Flush:
- Takes priority over accept and ack in the same cycle.
- Clears `count`, `full`, `wr_sel` and `rd_sel`. Bank contents are not cleared.

Reset:
- Sets `count=0`, `full=0`, `wr_sel=0`, `rd_sel=0`, and all bank storage to 0.
- Resulting outputs: `data_ready=1`, `out_valid=0`, `out_data=0`, `fill_count=0`.
- Reset mid-load discards everything, identically to flush plus zeroing the storage.

## Timing
- Accept latency: an element accepted at edge t is visible in storage after edge t.
- Set-complete latency: when the last element is accepted at edge t, `out_valid` is high in the cycle after edge t (one cycle).
- `out_data` is stable while `out_valid` is high and no ack has occurred.
- After an ack at edge t, `out_valid` reflects the other bank in the cycle after t. It stays high if that bank is already full.
- Back-pressure: with both banks full, `data_ready` is low. It rises combinationally in the cycle after the ack edge.
- No combinational path from `data_valid` to `data_ready`.
- Sustained throughput is one element per cycle when the consumer acks within `N_ELEMS` cycles of `out_valid`.

## Structure
- Package `operand_loader_pkg`:
  - `DATA_W_DEF = 8`
  - `N_ELEMS_DEF = 18`
  - a `cnt_w(n)` function
  - a `bank_sel_t` 1-bit typedef
- Sub-module `operand_bank`:
  - One `N_ELEMS x DATA_W` register array with write enable, write index, and synchronous active-low reset to zero.
  - Flat read bus output.
  - Instantiated twice.
- Top level holds the pointers, flags, counter, output mux, and handshake logic.

## Test plan
- Reset, then stream 18 elements 0x01..0x12 with `data_valid` held high and no ack. Required:
  - `out_valid` rises one cycle after the 18th accept.
  - `out_data[7:0]=0x01` and `out_data[143:136]=0x12`.
  - `data_ready` stays high and `fill_count` restarts at 0.
- With no ack, stream 36 elements. Required:
  - `data_ready` drops after the 36th accept.
  - A 37th element is held off.
  - Ack lowers nothing visible (`out_valid` stays high), `out_data` switches to bank 1, and `data_ready` rises next cycle.
- Continuous stream of 0x00..0xFF, acking each set on its first `out_valid` cycle. Required: no `data_ready` deassertion and every set in correct order.
- Same cycle: the last element of bank 1 is accepted while bank 0 is acked. Required: `out_valid` stays high, `out_data` shows bank 1, and `full=2'b10`.
- Load 7 elements, assert `flush`, then load 18 elements 0xA0..0xB1. Required: `fill_count=0` after flush, and the set presents 0xA0 at index 0.
- Assert `reset` low mid-load with `data_valid` high. Required: the next cycle shows `out_valid=0`, `out_data=0`, `fill_count=0`, `data_ready=1`.
